// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// debounce counter width and the default timing parameters.
`timescale 1ns/1ps
package key_pkg;

  localparam int CNT_W        = 24;
  localparam int CNT_MAX_DEF  = 999_999;
  localparam int LONG_MAX_DEF = 49_999_999;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; both flops reset to 1
// so an idle (released, active-low) key is seen from the first cycle.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/key_filter.sv
// Active-low push-button debouncer: one key_flag pulse per accepted press and
// a debounced level. Optional long-press pulse enabled by KEY_LONG_PRESS_EN.
`timescale 1ns/1ps
module key_filter
  import key_pkg::*;
#(
  parameter int CNT_MAX  = CNT_MAX_DEF,
  parameter int LONG_MAX = LONG_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic long_flag
`endif
);

  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             w_key_s;
  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_flag;
  logic             w_flag_nxt;
  logic             r_key_state;
  logic             w_key_state_nxt;

  sync_2ff u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (key_in),
    .q     (w_key_s)
  );

  // The entry sample counts as sample zero, so the incremented value reaching
  // CNT_MAX-1 marks the CNT_MAX-th consecutive matching sample.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      r_key_state <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_flag      <= w_flag_nxt;
      r_key_state <= w_key_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_flag_nxt      = 1'b0;
    w_key_state_nxt = r_key_state;
    case (r_state)
      IDLE: begin
        if (!w_key_s) begin
          w_state_nxt = PRESS_FILT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_FILT: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_HIT) begin
          w_state_nxt     = DOWN;
          w_cnt_nxt       = '0;
          w_flag_nxt      = 1'b1;
          w_key_state_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      DOWN: begin
        if (w_key_s) begin
          w_state_nxt = REL_FILT;
          w_cnt_nxt   = '0;
        end
      end
      REL_FILT: begin
        if (!w_key_s) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_HIT) begin
          w_state_nxt     = IDLE;
          w_cnt_nxt       = '0;
          w_key_state_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_flag  = r_flag;
  assign key_state = r_key_state;

`ifdef KEY_LONG_PRESS_EN
  localparam int                LONG_W   = $clog2(LONG_MAX + 1);
  localparam logic [LONG_W-1:0] LONG_HIT = LONG_W'(LONG_MAX - 1);

  logic [LONG_W-1:0] r_lcnt;
  logic [LONG_W-1:0] w_lcnt_inc;
  logic              w_hold;
  logic              r_long;

  // Counts cycles spent continuously in DOWN; saturating past the hit value
  // keeps the pulse to once per press however long the key stays down.
  assign w_hold     = (r_state == DOWN) && !w_key_s;
  assign w_lcnt_inc = (r_lcnt > LONG_HIT) ? r_lcnt : r_lcnt + LONG_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_lcnt <= w_hold ? w_lcnt_inc : '0;
      r_long <= w_hold && (r_lcnt == LONG_HIT);
    end
  end

  assign long_flag = r_long;
`else
  // Without the long-press option only the debounce path is built.
`endif

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter: directed scenarios plus random key
// activity, compared every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_key_filter;

  localparam int CNT_MAX  = 20;
  localparam int LONG_MAX = 100;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic key_in    = 1'b1;
  logic key_flag;
  logic key_state;
`ifdef KEY_LONG_PRESS_EN
  logic long_flag;
`endif

  always #10 sys_clk = ~sys_clk;

  key_filter #(
    .CNT_MAX  (CNT_MAX),
    .LONG_MAX (LONG_MAX)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state)
`ifdef KEY_LONG_PRESS_EN
    ,
    .long_flag (long_flag)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: two-sample delay, then a debounced level that flips only
  // after CNT_MAX consecutive samples disagreeing with it.
  logic m_s1, m_s2, m_lvl, m_flag, m_long;
  int   m_run, m_dwell;

  int   n_flag, last_flag, n_long, last_long, last_rise, t0;
  logic prev_state;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b1;
    m_flag = 1'b0; m_long = 1'b0; m_run = 0; m_dwell = 0;
  endtask

  task automatic model_step();
    logic s;
    s      = m_s2;
    m_s2   = m_s1;
    m_s1   = key_in;
    m_flag = 1'b0;
    m_long = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == CNT_MAX) begin
        m_lvl   = s;
        m_run   = 0;
        m_flag  = (s == 1'b0);
        m_dwell = 0;
      end
    end else begin
      if (m_lvl == 1'b0 && m_run == 0) begin
        m_dwell++;
        m_long = (m_dwell == LONG_MAX);
      end else begin
        m_dwell = 0;
      end
      m_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    if (sys_rst_n) model_step();
    else           model_reset();
    #1;
    check("key_flag", key_flag, m_flag);
    check("key_state", key_state, m_lvl);
`ifdef KEY_LONG_PRESS_EN
    check("long_flag", long_flag, m_long);
    if (long_flag === 1'b1) begin n_long++; last_long = cyc; end
`endif
    if (key_flag === 1'b1) begin n_flag++; last_flag = cyc; end
    if (prev_state === 1'b0 && key_state === 1'b1) last_rise = cyc;
    prev_state = key_state;
  endtask

  task automatic hold(input logic k, input int n);
    key_in = k;
    repeat (n) tick();
  endtask

  task automatic start_meas();
    t0 = cyc; n_flag = 0; n_long = 0;
    last_flag = -1; last_long = -1; last_rise = -1;
  endtask

  initial begin
    model_reset();
    prev_state = 1'b1;
    #2 sys_rst_n = 1'b0;
    #3;
    check("reset_key_state", key_state, 1'b1);
    check("reset_key_flag", key_flag, 1'b0);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    hold(1'b1, 5);

    // Clean press
    start_meas();
    hold(1'b0, 50);
    check_int("press_flag_count", n_flag, 1);
    check_int("press_latency", last_flag - t0, 22);
    check("press_level", key_state, 1'b0);
    hold(1'b1, 30);
    check("release_level", key_state, 1'b1);

    // Press bounce
    start_meas();
    for (int i = 0; i < 12; i++) hold(i[0], 5);
    hold(1'b1, 30);
    check_int("bounce_flag_count", n_flag, 0);
    check("bounce_level", key_state, 1'b1);

    // Release bounce
    start_meas();
    hold(1'b0, 40);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
    check("relbounce_still_down", key_state, 1'b0);
    t0 = cyc;
    hold(1'b1, 30);
    check_int("relbounce_flag_count", n_flag, 1);
    check_int("relbounce_release_latency", last_rise - t0, 22);

    // Reset in the middle of the press filter
    start_meas();
    hold(1'b0, 10);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_key_state", key_state, 1'b1);
    check("midrst_key_flag", key_flag, 1'b0);
    model_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    start_meas();
    repeat (40) tick();
    check_int("midrst_flag_count", n_flag, 1);
    check_int("midrst_latency", last_flag - t0, 22);
    hold(1'b1, 30);

    // Long press
    start_meas();
    hold(1'b0, 200);
    check_int("long_flag_count_key", n_flag, 1);
    check_int("long_key_latency", last_flag - t0, 22);
`ifdef KEY_LONG_PRESS_EN
    check_int("long_pulse_count", n_long, 1);
    check_int("long_pulse_latency", last_long - t0, 122);
`endif
    hold(1'b1, 30);

    // Random key activity
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) hold(1'(($urandom_range(0, 1))), $urandom_range(60, 140));
      else                           hold(1'(($urandom_range(0, 1))), $urandom_range(1, 30));
    end
    hold(1'b1, 30);
    check("final_level", key_state, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
